// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control sequencer.
package mc_ctrl_pkg;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

   typedef enum logic [2:0] {CLS_R, CLS_I, CLS_LW, CLS_SW, CLS_BR, CLS_JAL} cls_t;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   // Returns {unsupported, ALUctrl} for an R/I-type funct3.
   function automatic logic [3:0] alu_funct(input logic [2:0] funct3);
      case (funct3)
         3'b000:  return {1'b0, ALU_ADD};
         3'b111:  return {1'b0, ALU_AND};
         3'b110:  return {1'b0, ALU_OR};
         3'b010:  return {1'b0, ALU_SLT};
         default: return {1'b1, ALU_ADD};
      endcase
   endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct3/funct7[5] to class and datapath controls.
module mc_decode
   import mc_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output cls_t       cls,
   output logic [2:0] alu_ctrl,
   output logic       alu_src,
   output logic [1:0] imm_src,
   output logic       illegal
);

   logic [3:0] alu_fn;

   assign alu_fn = alu_funct(funct3);

   always_comb begin
      cls      = CLS_R;
      alu_ctrl = ALU_ADD;
      alu_src  = 1'b0;
      imm_src  = IMM_I;
      illegal  = 1'b0;
      case (opcode)
         OP_R: begin
            cls      = CLS_R;
            alu_ctrl = (funct3 == 3'b000 && funct7_5) ? ALU_SUB : alu_fn[2:0];
            illegal  = alu_fn[3];
         end
         OP_I: begin
            cls      = CLS_I;
            alu_ctrl = alu_fn[2:0];
            alu_src  = 1'b1;
            illegal  = alu_fn[3];
         end
         OP_LW: begin
            cls     = CLS_LW;
            alu_src = 1'b1;
         end
         OP_SW: begin
            cls     = CLS_SW;
            alu_src = 1'b1;
            imm_src = IMM_S;
         end
         OP_BR: begin
            // Only beq (000) and bne (001) are supported.
            cls      = CLS_BR;
            alu_ctrl = ALU_SUB;
            imm_src  = IMM_B;
            illegal  = (funct3[2:1] != 2'b00);
         end
         OP_JAL: begin
            cls     = CLS_JAL;
            imm_src = IMM_J;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning the IR and all datapath strobes.
// Define MC_CTRL_PERF_CNT_EN to add the cycle_cnt/instret_cnt performance counters.
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_WIDTH-1:0]    instr,
   input  logic                     imem_ack,
   input  logic                     EQ,
   input  logic                     dmem_ack,
   output logic                     imem_req,
   output logic                     dmem_req,
   output logic                     MemWrite,
   output logic                     IRWrite,
   output logic [DATA_WIDTH-1:0]    ir,
   output logic [ADDRESS_WIDTH-1:0] rs1,
   output logic [ADDRESS_WIDTH-1:0] rs2,
   output logic [ADDRESS_WIDTH-1:0] rd,
   output logic                     RegWrite,
   output logic [2:0]               ALUctrl,
   output logic                     ALUsrc,
   output logic [1:0]               ImmSrc,
   output logic [1:0]               Resultsrc,
   output logic                     PCWrite,
   output logic                     PCsrc,
   output logic                     halted
`ifdef MC_CTRL_PERF_CNT_EN
   ,
   output logic [31:0]              cycle_cnt,
   output logic [31:0]              instret_cnt
`endif
);

   state_t     state;
   cls_t       cls_q;
   logic       illegal_q;
   logic       pc_write_q;
   logic       pc_src_q;

   cls_t       dec_cls;
   logic [2:0] dec_alu_ctrl;
   logic       dec_alu_src;
   logic [1:0] dec_imm_src;
   logic       dec_illegal;

   logic       taken;
   logic       br_exec;
   logic       sw_done;

   mc_decode u_decode (
      .opcode   (instr[6:0]),
      .funct3   (instr[14:12]),
      .funct7_5 (instr[30]),
      .cls      (dec_cls),
      .alu_ctrl (dec_alu_ctrl),
      .alu_src  (dec_alu_src),
      .imm_src  (dec_imm_src),
      .illegal  (dec_illegal)
   );

   assign rs1 = ir[15 +: ADDRESS_WIDTH];
   assign rs2 = ir[20 +: ADDRESS_WIDTH];
   assign rd  = ir[7 +: ADDRESS_WIDTH];

   // EQ and dmem_ack are only valid in their own cycle, so branch resolution
   // and store retirement qualify the registered PC strobes directly.
   assign taken   = ir[12] ? !EQ : EQ;
   assign br_exec = (state == EXEC) && (cls_q == CLS_BR);
   assign sw_done = (state == MEM) && (cls_q == CLS_SW) && dmem_req && dmem_ack;
   assign PCWrite = pc_write_q | sw_done;
   assign PCsrc   = br_exec ? taken : pc_src_q;

   // Outputs are registered alongside the transition into the state they belong to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= FETCH;
         ir         <= '0;
         cls_q      <= CLS_R;
         illegal_q  <= 1'b0;
         imem_req   <= 1'b0;
         dmem_req   <= 1'b0;
         MemWrite   <= 1'b0;
         IRWrite    <= 1'b0;
         RegWrite   <= 1'b0;
         ALUctrl    <= ALU_ADD;
         ALUsrc     <= 1'b0;
         ImmSrc     <= IMM_I;
         Resultsrc  <= RES_ALU;
         pc_write_q <= 1'b0;
         pc_src_q   <= 1'b0;
         halted     <= 1'b0;
      end else begin
         IRWrite    <= 1'b0;
         RegWrite   <= 1'b0;
         pc_write_q <= 1'b0;
         case (state)
            FETCH: begin
               if (!imem_req) begin
                  imem_req <= 1'b1;
               end else if (imem_ack) begin
                  imem_req  <= 1'b0;
                  IRWrite   <= 1'b1;
                  ir        <= instr;
                  cls_q     <= dec_cls;
                  illegal_q <= dec_illegal;
                  ALUctrl   <= dec_alu_ctrl;
                  ALUsrc    <= dec_alu_src;
                  ImmSrc    <= dec_imm_src;
                  state     <= DECODE;
               end
            end
            DECODE: begin
               if (illegal_q) begin
                  state   <= HALT;
                  halted  <= 1'b1;
                  ALUctrl <= ALU_ADD;
                  ALUsrc  <= 1'b0;
                  ImmSrc  <= IMM_I;
               end else begin
                  state      <= EXEC;
                  pc_write_q <= (cls_q == CLS_BR);
               end
            end
            EXEC: begin
               case (cls_q)
                  CLS_LW, CLS_SW: begin
                     state    <= MEM;
                     dmem_req <= 1'b1;
                     MemWrite <= (cls_q == CLS_SW);
                  end
                  CLS_BR: begin
                     state    <= FETCH;
                     imem_req <= 1'b1;
                  end
                  default: begin
                     state      <= WB;
                     RegWrite   <= 1'b1;
                     pc_write_q <= 1'b1;
                     pc_src_q   <= (cls_q == CLS_JAL);
                     Resultsrc  <= (cls_q == CLS_JAL) ? RES_PC4 : RES_ALU;
                  end
               endcase
            end
            MEM: begin
               if (dmem_req && dmem_ack) begin
                  dmem_req <= 1'b0;
                  MemWrite <= 1'b0;
                  if (cls_q == CLS_LW) begin
                     state      <= WB;
                     RegWrite   <= 1'b1;
                     pc_write_q <= 1'b1;
                     pc_src_q   <= 1'b0;
                     Resultsrc  <= RES_MEM;
                  end else begin
                     state    <= FETCH;
                     imem_req <= 1'b1;
                  end
               end
            end
            WB: begin
               state     <= FETCH;
               imem_req  <= 1'b1;
               pc_src_q  <= 1'b0;
               Resultsrc <= RES_ALU;
            end
            HALT:    state <= HALT;
            default: state <= HALT;
         endcase
      end
   end

`ifdef MC_CTRL_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         if (state != HALT) cycle_cnt <= cycle_cnt + 32'd1;
         if (PCWrite) instret_cnt <= instret_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: directed program plus randomized instruction stream
// checked cycle by cycle against an instruction-level reference model.
module tb_mc_ctrl_fsm;

   localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_JAL = 5, K_BAD = 6;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr = '0;
   logic        imem_ack = 1'b0;
   logic        EQ = 1'b0;
   logic        dmem_ack = 1'b0;
   logic        imem_req, dmem_req, MemWrite, IRWrite, RegWrite, ALUsrc;
   logic        PCWrite, PCsrc, halted;
   logic [31:0] ir;
   logic [4:0]  rs1, rs2, rd;
   logic [2:0]  ALUctrl;
   logic [1:0]  ImmSrc, Resultsrc;
`ifdef MC_CTRL_PERF_CNT_EN
   logic [31:0] cycle_cnt, instret_cnt;
`endif

   int tests = 0;
   int failed = 0;
   int exp_cycles = 0;
   int exp_retired = 0;
   bit model_halt = 1'b0;

   mc_ctrl_fsm #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .instr(instr), .imem_ack(imem_ack), .EQ(EQ), .dmem_ack(dmem_ack),
      .imem_req(imem_req), .dmem_req(dmem_req), .MemWrite(MemWrite), .IRWrite(IRWrite), .ir(ir),
      .rs1(rs1), .rs2(rs2), .rd(rd), .RegWrite(RegWrite), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc),
      .ImmSrc(ImmSrc), .Resultsrc(Resultsrc), .PCWrite(PCWrite), .PCsrc(PCsrc), .halted(halted)
`ifdef MC_CTRL_PERF_CNT_EN
      , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge; every rising edge outside reset and HALT is a counted cycle.
   task automatic tick();
      @(negedge clk);
      if (!rst && !model_halt) exp_cycles++;
   endtask

   task automatic check_idle(input string tag);
      checkOutput({tag, "/imem_req"}, imem_req, 0);
      checkOutput({tag, "/dmem_req"}, dmem_req, 0);
      checkOutput({tag, "/MemWrite"}, MemWrite, 0);
      checkOutput({tag, "/IRWrite"}, IRWrite, 0);
      checkOutput({tag, "/RegWrite"}, RegWrite, 0);
      checkOutput({tag, "/PCWrite"}, PCWrite, 0);
   endtask

   task automatic check_counters(input string tag);
`ifdef MC_CTRL_PERF_CNT_EN
      checkOutput({tag, "/cycle_cnt"}, cycle_cnt, exp_cycles);
      checkOutput({tag, "/instret_cnt"}, instret_cnt, exp_retired);
`else
      if (tag.len() == 0) $display("[TB] no counters");
`endif
   endtask

   // Reference decode straight from the instruction-set table.
   function automatic void ref_decode(input logic [31:0] i, output int kind, output logic [2:0] alu,
                                      output logic src, output logic [1:0] imm, output logic bad);
      logic [2:0] f3 = i[14:12];
      kind = K_BAD; alu = 3'd0; src = 1'b0; imm = 2'd0; bad = 1'b0;
      case (i[6:0])
         7'b0110011: kind = K_R;
         7'b0010011: kind = K_I;
         7'b0000011: kind = K_LW;
         7'b0100011: kind = K_SW;
         7'b1100011: kind = K_BR;
         7'b1101111: kind = K_JAL;
         default:    kind = K_BAD;
      endcase
      if (kind == K_R || kind == K_I) begin
         src = (kind == K_I);
         if (f3 == 3'b000)      alu = (kind == K_R && i[30]) ? 3'd1 : 3'd0;
         else if (f3 == 3'b111) alu = 3'd2;
         else if (f3 == 3'b110) alu = 3'd3;
         else if (f3 == 3'b010) alu = 3'd5;
         else                   bad = 1'b1;
      end else if (kind == K_LW) begin
         src = 1'b1;
      end else if (kind == K_SW) begin
         src = 1'b1; imm = 2'd1;
      end else if (kind == K_BR) begin
         alu = 3'd1; imm = 2'd2; bad = (f3 != 3'b000 && f3 != 3'b001);
      end else if (kind == K_JAL) begin
         imm = 2'd3;
      end else begin
         bad = 1'b1;
      end
   endfunction

   function automatic logic [31:0] make_instr(input int kind);
      logic [31:0] r = $urandom;
      logic [2:0] alu_f3 [4] = '{3'b000, 3'b111, 3'b110, 3'b010};
      case (kind)
         K_R:     begin r[6:0] = 7'b0110011; r[14:12] = alu_f3[$urandom_range(0, 3)];
                        r[31:25] = ($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'b0000000; end
         K_I:     begin r[6:0] = 7'b0010011; r[14:12] = alu_f3[$urandom_range(0, 3)]; end
         K_LW:    begin r[6:0] = 7'b0000011; r[14:12] = 3'b010; end
         K_SW:    begin r[6:0] = 7'b0100011; r[14:12] = 3'b010; end
         K_BR:    begin r[6:0] = 7'b1100011; r[14:12] = {2'b00, 1'($urandom_range(0, 1))}; end
         default: r[6:0] = 7'b1101111;
      endcase
      return r;
   endfunction

   // Drive one instruction through its full lifetime; entered at a falling edge with the DUT in FETCH.
   task automatic applyStimulus(input logic [31:0] word, input int fetch_wait, input int mem_wait, input logic eq);
      int kind; logic [2:0] alu; logic src; logic [1:0] imm; logic bad;
      logic exp_taken;
      ref_decode(word, kind, alu, src, imm, bad);
      for (int w = 0; w < fetch_wait; w++) begin
         imem_ack = 1'b0; instr = $urandom; #1;
         checkOutput("fetch_wait/imem_req", imem_req, 1);
         checkOutput("fetch_wait/PCWrite", PCWrite, 0);
         tick();
      end
      imem_ack = 1'b1; instr = word; #1;
      checkOutput("fetch_ack/imem_req", imem_req, 1);
      tick();
      imem_ack = 1'b0; instr = $urandom; dmem_ack = 1'b1; #1;
      checkOutput("decode/IRWrite", IRWrite, 1);
      checkOutput("decode/ir", ir, word);
      checkOutput("decode/rd", rd, word[11:7]);
      checkOutput("decode/rs1", rs1, word[19:15]);
      checkOutput("decode/rs2", rs2, word[24:20]);
      checkOutput("decode/imem_req", imem_req, 0);
      checkOutput("decode/PCWrite", PCWrite, 0);
      if (!bad) begin
         checkOutput("decode/ALUctrl", ALUctrl, alu);
         checkOutput("decode/ALUsrc", ALUsrc, src);
         checkOutput("decode/ImmSrc", ImmSrc, imm);
      end
      tick();
      dmem_ack = 1'b0;
      if (bad) begin
         model_halt = 1'b1;
         return;
      end
      EQ = eq; imem_ack = 1'b1; #1;
      exp_taken = word[12] ? !eq : eq;
      checkOutput("exec/PCWrite", PCWrite, kind == K_BR);
      if (kind == K_BR) checkOutput("exec/PCsrc", PCsrc, exp_taken);
      checkOutput("exec/RegWrite", RegWrite, 0);
      checkOutput("exec/ALUctrl", ALUctrl, alu);
      checkOutput("exec/ImmSrc", ImmSrc, imm);
      tick();
      imem_ack = 1'b0;
      if (kind == K_BR) begin
         exp_retired++;
         return;
      end
      if (kind == K_LW || kind == K_SW) begin
         for (int w = 0; w < mem_wait; w++) begin
            dmem_ack = 1'b0; #1;
            checkOutput("mem_wait/dmem_req", dmem_req, 1);
            checkOutput("mem_wait/MemWrite", MemWrite, kind == K_SW);
            checkOutput("mem_wait/PCWrite", PCWrite, 0);
            tick();
         end
         dmem_ack = 1'b1; #1;
         checkOutput("mem_ack/dmem_req", dmem_req, 1);
         checkOutput("mem_ack/MemWrite", MemWrite, kind == K_SW);
         checkOutput("mem_ack/PCWrite", PCWrite, kind == K_SW);
         checkOutput("mem_ack/RegWrite", RegWrite, 0);
         if (kind == K_SW) checkOutput("mem_ack/PCsrc", PCsrc, 0);
         tick();
         dmem_ack = 1'b0;
         if (kind == K_SW) begin
            exp_retired++;
            return;
         end
      end
      #1;
      checkOutput("wb/RegWrite", RegWrite, 1);
      checkOutput("wb/PCWrite", PCWrite, 1);
      checkOutput("wb/PCsrc", PCsrc, kind == K_JAL);
      checkOutput("wb/Resultsrc", Resultsrc, (kind == K_LW) ? 1 : (kind == K_JAL) ? 2 : 0);
      checkOutput("wb/dmem_req", dmem_req, 0);
      tick();
      exp_retired++;
   endtask

   // Release reset and spend the first FETCH cycle, where the request is still low and an ack is ignored.
   task automatic restart();
      rst = 1'b0; exp_cycles = 0; exp_retired = 0; model_halt = 1'b0;
      imem_ack = 1'b1; instr = 32'h00500093; #1;
      checkOutput("restart/imem_req", imem_req, 0);
      tick();
      imem_ack = 1'b0; #1;
      checkOutput("restart/imem_req_up", imem_req, 1);
      checkOutput("restart/IRWrite", IRWrite, 0);
      tick();
      exp_cycles = 2;
   endtask

   initial begin
      tick(); tick(); #1;
      check_idle("reset");
      checkOutput("reset/ir", ir, 0);
      checkOutput("reset/halted", halted, 0);
      checkOutput("reset/ALUctrl", ALUctrl, 0);
      checkOutput("reset/ImmSrc", ImmSrc, 0);
      checkOutput("reset/Resultsrc", Resultsrc, 0);
      check_counters("reset");
      restart();

      applyStimulus(32'h00500093, 1, 0, 1'b0);   // addi x1,x0,5
      applyStimulus(32'h0040A103, 0, 3, 1'b0);   // lw x2,4(x1)
      applyStimulus(32'h0020A423, 2, 1, 1'b0);   // sw x2,8(x1)
      check_counters("prog3");
      applyStimulus(32'h00208463, 0, 0, 1'b1);   // beq taken
      applyStimulus(32'h00208463, 1, 0, 1'b0);   // beq not taken
      applyStimulus(32'h00209463, 0, 0, 1'b1);   // bne not taken
      applyStimulus(32'h00209463, 0, 0, 1'b0);   // bne taken
      applyStimulus(32'h008000EF, 0, 0, 1'b0);   // jal x1,8
      applyStimulus(32'h40208033, 0, 0, 1'b0);   // sub x0,x1,x2
      check_counters("directed");

      for (int n = 0; n < 40; n++) begin
         applyStimulus(make_instr($urandom_range(0, 5)), $urandom_range(0, 3), $urandom_range(0, 3),
                       1'($urandom_range(0, 1)));
         check_counters("random");
      end

      // Reset asserted while a store is waiting in MEM.
      imem_ack = 1'b1; instr = 32'h0020A423; tick();
      imem_ack = 1'b0; tick(); tick(); #1;
      checkOutput("mid_mem/dmem_req", dmem_req, 1);
      checkOutput("mid_mem/MemWrite", MemWrite, 1);
      rst = 1'b1; #1;
      check_idle("mid_mem_reset");
      checkOutput("mid_mem_reset/ir", ir, 0);
      tick();
      restart();
      applyStimulus(32'h00500093, 0, 0, 1'b0);
      check_counters("after_reset");

      applyStimulus(32'h0000007F, 0, 0, 1'b0);
      for (int n = 0; n < 6; n++) begin
         imem_ack = 1'($urandom_range(0, 1)); dmem_ack = 1'($urandom_range(0, 1)); #1;
         checkOutput("halt/halted", halted, 1);
         check_idle("halt");
         tick();
      end
      check_counters("halt");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
